stage_write_q: RTL

- Parametrised successor to the single-register writeback stage.
- Sits between memory1 and the register file/CSR unit.
- Buffers up to DEPTH completed results in a FIFO so memory1 keeps retiring while an excepting instruction waits for in-flight bus transactions to finish.
- Provides NUM_FWD combinational forwarding lookups to decode, and squashes younger entries on exception.

---
 rtl/stage_write_q_pkg.sv | 49 ++++
 rtl/stage_write_q_wb_fifo.sv | 100 ++++++++++
 rtl/stage_write_q.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_write_q_pkg.sv
// Shared writeback definitions: exception causes, FSM states, queue entry
// and forwarding-view records used by stage_write_q and its wb_fifo.
// Optional feature macro used by this slice: WB_RETIRE_COUNT_EN.
package stage_write_q_pkg;

   // Result width carried by queue entries; stage_write_q's XLEN must match.
   localparam int unsigned WB_XLEN = 32;

   typedef enum logic [3:0] {
      ECAUSE_INSN_MISALIGN  = 4'd0,
      ECAUSE_INSN_FAULT     = 4'd1,
      ECAUSE_ILLEGAL_INSN   = 4'd2,
      ECAUSE_BREAKPOINT     = 4'd3,
      ECAUSE_LOAD_MISALIGN  = 4'd4,
      ECAUSE_LOAD_FAULT     = 4'd5,
      ECAUSE_STORE_MISALIGN = 4'd6,
      ECAUSE_STORE_FAULT    = 4'd7,
      ECAUSE_ECALL_U        = 4'd8,
      ECAUSE_ECALL_M        = 4'd11
   } ecause_t;

   typedef enum logic [0:0] {
      WB_RUN      = 1'b0,
      WB_EXC_WAIT = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
      logic               exc;
      ecause_t            cause;
      logic               flush;
      logic [29:0]        pc;
   } wb_entry_t;

   // Per-slot view exported by the FIFO, ordered oldest (0) to newest.
   typedef struct packed {
      logic               vld;
      logic [4:0]         rd;
      logic               exc;
      logic [WB_XLEN-1:0] data;
   } wb_fwd_t;

   // Register x0 never forwards; any other register forwards on exact match.
   function automatic logic fwd_reg_match(input logic [4:0] lookup, input logic [4:0] dest);
      return (lookup != 5'd0) && (lookup == dest);
   endfunction

endpackage

// File: rtl/stage_write_q_wb_fifo.sv
// wb_fifo: circular buffer of completed results with push/pop/clear,
// occupancy count and an age-ordered slot view for forwarding lookups.
module wb_fifo
   import stage_write_q_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clear_i,
   input  logic           push_i,
   input  wb_entry_t      push_entry_i,
   input  logic           pop_i,
   output wb_entry_t      head_o,
   output logic [CW-1:0]  count_o,
   output wb_fwd_t        fwd_view_o [DEPTH]
);

   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   wb_entry_t     mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign push_ok_s = push_i && (cnt_q != CNT_FULL);
   assign pop_ok_s  = pop_i && (cnt_q != CNT_ZERO);

   // Pointer and occupancy update; clear wins over push and pop.
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_d = wr_q + 1'b1;
         end else begin
            wr_d = wr_q;
         end
         if (pop_ok_s) begin
            rd_d = rd_q + 1'b1;
         end else begin
            rd_d = rd_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= CNT_ZERO;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; a push in a clearing cycle is dropped with the rest.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else if (push_ok_s && !clear_i) begin
         mem_q[wr_q] <= push_entry_i;
      end else begin
         mem_q <= mem_q;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   for (genvar k = 0; k < DEPTH; k++) begin : g_view
      logic [PW-1:0] idx_s;
      assign idx_s              = rd_q + PW'(k);
      assign fwd_view_o[k].vld  = (CW'(k) < cnt_q);
      assign fwd_view_o[k].rd   = mem_q[idx_s].rd;
      assign fwd_view_o[k].exc  = mem_q[idx_s].exc;
      assign fwd_view_o[k].data = mem_q[idx_s].data;
   end

endmodule

// File: rtl/stage_write_q.sv
// stage_write_q: queued writeback stage. Completed results from memory1 are
// buffered so an excepting instruction can wait for bus activity to drain;
// the exception then squashes everything younger. Decode gets combinational
// forwarding from the queue and the output register.
// Optional feature macro: WB_RETIRE_COUNT_EN (adds a 64-bit retire counter).
module stage_write_q
   import stage_write_q_pkg::*;
#(
   parameter int unsigned XLEN    = WB_XLEN,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic                    clk_core,
   input  logic                    reset,
   input  logic                    fe1_stall,
   input  logic                    mem1_stall,
   input  logic                    mem1_valid_wb,
   input  logic                    mem1_exc,
   input  ecause_t                 mem1_exc_cause,
   input  logic                    mem1_flush,
   input  logic [29:0]             mem1_pc,
   input  logic [4:0]              mem1_wb_reg,
   input  logic [XLEN-1:0]         mem1_dout,
   output logic                    wb_stall,
   output logic                    wb_valid,
   output logic [4:0]              wb_reg,
   output logic [XLEN-1:0]         wb_data,
   output logic                    wb_exc,
   output ecause_t                 wb_exc_cause,
   output logic                    wb_flush,
   output logic [29:0]             wb_pc,
`ifdef WB_RETIRE_COUNT_EN
   output logic [63:0]             retire_count,
`endif
   input  logic [NUM_FWD*5-1:0]    fwd_reg,
   output logic [NUM_FWD-1:0]      fwd_hit,
   output logic [NUM_FWD*XLEN-1:0] fwd_data
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   wb_state_t     state_q, state_d;
   wb_entry_t     in_entry_s;
   wb_entry_t     fifo_head_s;
   wb_entry_t     head_s;
   wb_fwd_t       fwd_view_s [DEPTH];
   logic [CW-1:0] fifo_count_s;
   logic          fifo_empty_s;
   logic          full_s;
   logic          accept_s;
   logic          have_head_s;
   logic          ext_stall_s;
   logic          pop_s;
   logic          exc_pop_s;
   logic          bypass_s;
   logic          fifo_push_s;
   logic          fifo_pop_s;

   logic            wb_valid_q, wb_valid_d;
   logic            wb_exc_q, wb_exc_d;
   logic            wb_flush_q, wb_flush_d;
   logic [4:0]      wb_reg_q, wb_reg_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [29:0]     wb_pc_q, wb_pc_d;
   ecause_t         wb_exc_cause_q, wb_exc_cause_d;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_core),
      .rst_i        (reset),
      .clear_i      (exc_pop_s),
      .push_i       (fifo_push_s),
      .push_entry_i (in_entry_s),
      .pop_i        (fifo_pop_s),
      .head_o       (fifo_head_s),
      .count_o      (fifo_count_s),
      .fwd_view_o   (fwd_view_s)
   );

   // Stall depends only on the registered occupancy, never on this cycle's pop.
   assign full_s       = (fifo_count_s == CNT_FULL);
   assign fifo_empty_s = (fifo_count_s == CNT_ZERO);
   assign wb_stall     = full_s;

   // Retire decision, FSM next state and next output-register contents.
   always_comb begin
      in_entry_s.rd    = mem1_wb_reg;
      in_entry_s.data  = mem1_dout;
      in_entry_s.exc   = mem1_exc;
      in_entry_s.cause = mem1_exc_cause;
      in_entry_s.flush = mem1_flush;
      in_entry_s.pc    = mem1_pc;

      accept_s    = (mem1_valid_wb || mem1_exc) && !full_s;
      have_head_s = !fifo_empty_s || accept_s;
      head_s      = fifo_empty_s ? in_entry_s : fifo_head_s;
      ext_stall_s = fe1_stall || mem1_stall;

      state_d   = state_q;
      pop_s     = 1'b0;
      exc_pop_s = 1'b0;
      case (state_q)
         WB_RUN: begin
            if (have_head_s) begin
               if (head_s.exc) begin
                  if (ext_stall_s) begin
                     state_d = WB_EXC_WAIT;
                  end else begin
                     pop_s     = 1'b1;
                     exc_pop_s = 1'b1;
                  end
               end else begin
                  pop_s = 1'b1;
               end
            end else begin
               pop_s = 1'b0;
            end
         end
         WB_EXC_WAIT: begin
            // Leave once bus activity ends; the exception retires next cycle.
            if (!ext_stall_s) begin
               state_d = WB_RUN;
            end else begin
               state_d = WB_EXC_WAIT;
            end
         end
         default: begin
            state_d = WB_RUN;
         end
      endcase

      // An empty queue hands the accepted input directly to the output register.
      bypass_s    = pop_s && fifo_empty_s;
      fifo_pop_s  = pop_s && !fifo_empty_s;
      fifo_push_s = accept_s && !bypass_s && !exc_pop_s;

      wb_valid_d     = 1'b0;
      wb_exc_d       = 1'b0;
      wb_flush_d     = 1'b0;
      wb_reg_d       = wb_reg_q;
      wb_data_d      = wb_data_q;
      wb_pc_d        = wb_pc_q;
      wb_exc_cause_d = wb_exc_cause_q;
      if (pop_s) begin
         wb_reg_d       = head_s.rd;
         wb_data_d      = head_s.data;
         wb_pc_d        = head_s.pc;
         wb_exc_cause_d = head_s.cause;
         if (exc_pop_s) begin
            wb_exc_d = 1'b1;
         end else begin
            wb_valid_d = (head_s.rd != 5'd0);
            wb_flush_d = head_s.flush;
         end
      end else begin
         wb_valid_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         state_q <= WB_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Retire output register.
   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         wb_valid_q     <= 1'b0;
         wb_exc_q       <= 1'b0;
         wb_flush_q     <= 1'b0;
         wb_reg_q       <= 5'd0;
         wb_data_q      <= '0;
         wb_pc_q        <= 30'd0;
         wb_exc_cause_q <= ecause_t'(4'd0);
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_exc_q       <= wb_exc_d;
         wb_flush_q     <= wb_flush_d;
         wb_reg_q       <= wb_reg_d;
         wb_data_q      <= wb_data_d;
         wb_pc_q        <= wb_pc_d;
         wb_exc_cause_q <= wb_exc_cause_d;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_exc       = wb_exc_q;
   assign wb_flush     = wb_flush_q;
   assign wb_reg       = wb_reg_q;
   assign wb_data      = wb_data_q;
   assign wb_pc        = wb_pc_q;
   assign wb_exc_cause = wb_exc_cause_q;

   // Forwarding: output register first, then queue oldest->newest so the
   // youngest matching non-excepting result wins.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (wb_valid_q && fwd_reg_match(fwd_reg[i*5 +: 5], wb_reg_q)) begin
            fwd_hit[i]              = 1'b1;
            fwd_data[i*XLEN +: XLEN] = wb_data_q;
         end else begin
            fwd_hit[i] = fwd_hit[i];
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (fwd_view_s[k].vld && !fwd_view_s[k].exc &&
                fwd_reg_match(fwd_reg[i*5 +: 5], fwd_view_s[k].rd)) begin
               fwd_hit[i]              = 1'b1;
               fwd_data[i*XLEN +: XLEN] = fwd_view_s[k].data;
            end else begin
               fwd_hit[i] = fwd_hit[i];
            end
         end
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] retire_cnt_q;

   // Count every non-exception retirement, x0 writes included.
   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         retire_cnt_q <= 64'd0;
      end else if (pop_s && !exc_pop_s) begin
         retire_cnt_q <= retire_cnt_q + 64'd1;
      end else begin
         retire_cnt_q <= retire_cnt_q;
      end
   end

   assign retire_count = retire_cnt_q;
`endif

endmodule
